// File: rtl/inventario_dual_if.sv
// Purpose: bundles the sale/restock/error-clear inputs and the availability,
//          count, status and error outputs of the dual-product stock keeper.
// Signals:
//   sale_a, sale_b        one-unit sale events from the sale controller (L / L2)
//   restock_a, restock_b  operator restock events
//   err_clr               clears the sticky sale-on-empty errors
//   E, E2                 product available flags (count != 0)
//   stock_a, stock_b      current counts, WIDTH bits
//   status_a, status_b    00 EMPTY, 01 LOW, 10 OK, 11 FULL
//   err_a, err_b          sticky sale-on-empty errors
// Modports: master drives the events and observes the results; slave is the
//           stock keeper itself.
interface inventario_dual_if #(
    parameter int WIDTH = 4
);
    logic             sale_a;
    logic             sale_b;
    logic             restock_a;
    logic             restock_b;
    logic             err_clr;
    logic             E;
    logic             E2;
    logic [WIDTH-1:0] stock_a;
    logic [WIDTH-1:0] stock_b;
    logic [1:0]       status_a;
    logic [1:0]       status_b;
    logic             err_a;
    logic             err_b;

    modport master (
        output sale_a, sale_b, restock_a, restock_b, err_clr,
        input  E, E2, stock_a, stock_b, status_a, status_b, err_a, err_b
    );

    modport slave (
        input  sale_a, sale_b, restock_a, restock_b, err_clr,
        output E, E2, stock_a, stock_b, status_a, status_b, err_a, err_b
    );
endinterface

// File: rtl/inventario_dual.sv
// Purpose: stock keeper for the two products of the vending machine. Counts
//          sales and restocks per product, reports availability (E/E2) that
//          the sale controller samples before accepting an order, decodes a
//          per-product EMPTY/LOW/OK/FULL status and flags sales on empty.
// Ports:
//   clk1    system clock, rising edge
//   reset1  synchronous active-high reset, priority over all other inputs
//   bus     inventario_dual_if.slave (events in, counts/flags/status out)
// Only the counts and the error flags are registers; E/E2 and status are
// decoded from the registered counts, so they move together with the count.
module inventario_dual #(
    parameter int WIDTH       = 4,
    parameter int MAX_STOCK   = 9,
    parameter int INIT_STOCK  = 5,
    parameter int RESTOCK_AMT = 3,
    parameter int LOW_THRESH  = 2
) (
    input  logic                 clk1,
    input  logic                 reset1,
    inventario_dual_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_LOW   = 2'b01,
        ST_OK    = 2'b10,
        ST_FULL  = 2'b11
    } status_t;

    localparam logic [WIDTH-1:0] INIT_C    = WIDTH'(INIT_STOCK);
    localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MAX_STOCK);
    localparam logic [WIDTH-1:0] LOW_C     = WIDTH'(LOW_THRESH);
    localparam logic [WIDTH:0]   MAX_WIDE  = (WIDTH+1)'(MAX_STOCK);
    localparam logic [WIDTH:0]   RSTK_WIDE = (WIDTH+1)'(RESTOCK_AMT);

    // The sale is judged against the pre-edge count, so a restock in the same
    // cycle cannot rescue a sale on empty. The sum is formed one bit wider
    // than the counter so the clamp sees the true value, never a wrapped one.
    function automatic logic [WIDTH-1:0] next_count(
        input logic [WIDTH-1:0] c,
        input logic             sale,
        input logic             restock
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, c};
        if (sale && (c != {WIDTH{1'b0}})) begin
            sum = sum - {{WIDTH{1'b0}}, 1'b1};
        end else begin
            sum = sum;
        end
        if (restock) begin
            sum = sum + RSTK_WIDE;
        end else begin
            sum = sum;
        end
        if (sum > MAX_WIDE) begin
            sum = MAX_WIDE;
        end else begin
            sum = sum;
        end
        return sum[WIDTH-1:0];
    endfunction

    // Sticky error: a new violation wins over a simultaneous clear.
    function automatic logic next_err(
        input logic             err,
        input logic [WIDTH-1:0] c,
        input logic             sale,
        input logic             clr
    );
        logic n;
        if (sale && (c == {WIDTH{1'b0}})) begin
            n = 1'b1;
        end else if (clr) begin
            n = 1'b0;
        end else begin
            n = err;
        end
        return n;
    endfunction

    // FULL is tested before LOW so it wins if the two ranges ever overlap.
    function automatic status_t decode_status(input logic [WIDTH-1:0] c);
        status_t s;
        if (c == {WIDTH{1'b0}}) begin
            s = ST_EMPTY;
        end else if (c == MAX_C) begin
            s = ST_FULL;
        end else if (c <= LOW_C) begin
            s = ST_LOW;
        end else begin
            s = ST_OK;
        end
        return s;
    endfunction

    logic [WIDTH-1:0] stock_a_r;
    logic [WIDTH-1:0] stock_b_r;
    logic             err_a_r;
    logic             err_b_r;
    logic [WIDTH-1:0] stock_a_nxt_s;
    logic [WIDTH-1:0] stock_b_nxt_s;
    logic             err_a_nxt_s;
    logic             err_b_nxt_s;
    status_t          status_a_s;
    status_t          status_b_s;

    // Next-state computation for both products (independent, same rules).
    always_comb begin
        stock_a_nxt_s = next_count(stock_a_r, bus.sale_a, bus.restock_a);
        stock_b_nxt_s = next_count(stock_b_r, bus.sale_b, bus.restock_b);
        err_a_nxt_s   = next_err(err_a_r, stock_a_r, bus.sale_a, bus.err_clr);
        err_b_nxt_s   = next_err(err_b_r, stock_b_r, bus.sale_b, bus.err_clr);
    end

    // Count and error registers; reset discards any event in the same cycle.
    always_ff @(posedge clk1) begin
        if (reset1) begin
            stock_a_r <= INIT_C;
            stock_b_r <= INIT_C;
            err_a_r   <= 1'b0;
            err_b_r   <= 1'b0;
        end else begin
            stock_a_r <= stock_a_nxt_s;
            stock_b_r <= stock_b_nxt_s;
            err_a_r   <= err_a_nxt_s;
            err_b_r   <= err_b_nxt_s;
        end
    end

    // Status decode from the registered counts.
    always_comb begin
        status_a_s = decode_status(stock_a_r);
        status_b_s = decode_status(stock_b_r);
    end

    assign bus.stock_a  = stock_a_r;
    assign bus.stock_b  = stock_b_r;
    assign bus.err_a    = err_a_r;
    assign bus.err_b    = err_b_r;
    assign bus.E        = (stock_a_r != {WIDTH{1'b0}});
    assign bus.E2       = (stock_b_r != {WIDTH{1'b0}});
    assign bus.status_a = status_a_s;
    assign bus.status_b = status_b_s;

endmodule

// File: tb/tb_inventario_dual.sv
// Directed bench for inventario_dual: reset, sales down to empty, sale on
// empty with sticky error and clear, restock saturation, combined
// sale+restock cases, clear-vs-set priority and reset mid-operation.
module tb_inventario_dual;

    logic clk1;
    logic reset1;
    int   n_cmp;
    int   n_fail;

    inventario_dual_if #(.WIDTH(4)) bus ();

    inventario_dual #(
        .WIDTH(4), .MAX_STOCK(9), .INIT_STOCK(5), .RESTOCK_AMT(3), .LOW_THRESH(2)
    ) dut (
        .clk1   (clk1),
        .reset1 (reset1),
        .bus    (bus.slave)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from the edge.
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle_inputs();
        bus.sale_a    = 1'b0;
        bus.sale_b    = 1'b0;
        bus.restock_a = 1'b0;
        bus.restock_b = 1'b0;
        bus.err_clr   = 1'b0;
        reset1        = 1'b0;
    endtask

    logic [3:0] exp_stock [5];
    logic [1:0] exp_stat  [5];

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        idle_inputs();
        exp_stock = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        exp_stat  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};

        // 1: reset
        reset1 = 1'b1;
        step();
        reset1 = 1'b0;
        check("rst_stock_a", 32'(bus.stock_a), 32'd5);
        check("rst_stock_b", 32'(bus.stock_b), 32'd5);
        check("rst_E", 32'(bus.E), 32'd1);
        check("rst_E2", 32'(bus.E2), 32'd1);
        check("rst_status_a", 32'(bus.status_a), 32'd2);
        check("rst_status_b", 32'(bus.status_b), 32'd2);
        check("rst_err_a", 32'(bus.err_a), 32'd0);
        check("rst_err_b", 32'(bus.err_b), 32'd0);

        // 2: five sales of A
        for (int i = 0; i < 5; i++) begin
            bus.sale_a = 1'b1;
            step();
            bus.sale_a = 1'b0;
            check("sale_stock_a", 32'(bus.stock_a), 32'(exp_stock[i]));
            check("sale_status_a", 32'(bus.status_a), 32'(exp_stat[i]));
        end
        check("empty_E", 32'(bus.E), 32'd0);
        check("empty_stock_b", 32'(bus.stock_b), 32'd5);
        check("empty_E2", 32'(bus.E2), 32'd1);
        check("empty_err_a", 32'(bus.err_a), 32'd0);

        // 3: sale on empty, sticky error, clear
        bus.sale_a = 1'b1;
        step();
        bus.sale_a = 1'b0;
        check("soe_stock_a", 32'(bus.stock_a), 32'd0);
        check("soe_err_a", 32'(bus.err_a), 32'd1);
        check("soe_err_b", 32'(bus.err_b), 32'd0);
        step();
        check("sticky_err_a", 32'(bus.err_a), 32'd1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("clr_err_a", 32'(bus.err_a), 32'd0);

        // 4: restock B to saturation
        bus.restock_b = 1'b1;
        step();
        check("rstk_b_8", 32'(bus.stock_b), 32'd8);
        check("rstk_b_8_status", 32'(bus.status_b), 32'd2);
        step();
        check("rstk_b_9", 32'(bus.stock_b), 32'd9);
        check("rstk_b_9_status", 32'(bus.status_b), 32'd3);
        step();
        bus.restock_b = 1'b0;
        check("rstk_b_sat", 32'(bus.stock_b), 32'd9);
        check("rstk_b_sat_status", 32'(bus.status_b), 32'd3);

        // 5a: sale+restock on empty, with err_clr in the same cycle (set wins)
        bus.sale_a    = 1'b1;
        bus.restock_a = 1'b1;
        bus.err_clr   = 1'b1;
        step();
        idle_inputs();
        check("sr0_stock_a", 32'(bus.stock_a), 32'd3);
        check("sr0_err_a", 32'(bus.err_a), 32'd1);
        check("sr0_status_a", 32'(bus.status_a), 32'd2);

        // bring A to 4: 3 -> 6 -> 5 -> 4
        bus.restock_a = 1'b1;
        step();
        bus.restock_a = 1'b0;
        check("pre_stock_6", 32'(bus.stock_a), 32'd6);
        bus.sale_a = 1'b1;
        step();
        step();
        bus.sale_a = 1'b0;
        check("pre_stock_4", 32'(bus.stock_a), 32'd4);

        // 5b: sale+restock from 4 -> 6
        bus.sale_a    = 1'b1;
        bus.restock_a = 1'b1;
        step();
        idle_inputs();
        check("sr4_stock_a", 32'(bus.stock_a), 32'd6);
        check("sr4_err_a_kept", 32'(bus.err_a), 32'd1);

        // 5c: from 9, sale+restock stays 9
        bus.restock_a = 1'b1;
        step();
        bus.restock_a = 1'b0;
        check("pre_stock_9", 32'(bus.stock_a), 32'd9);
        bus.sale_a    = 1'b1;
        bus.restock_a = 1'b1;
        step();
        idle_inputs();
        check("sr9_stock_a", 32'(bus.stock_a), 32'd9);
        check("sr9_status_a", 32'(bus.status_a), 32'd3);

        // 6: down to 2 then reset with a sale pending
        bus.sale_a = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        bus.sale_a = 1'b0;
        check("pre_rst_stock_a", 32'(bus.stock_a), 32'd2);
        check("pre_rst_status_a", 32'(bus.status_a), 32'd1);
        reset1        = 1'b1;
        bus.sale_a    = 1'b1;
        bus.restock_b = 1'b1;
        step();
        idle_inputs();
        check("mid_rst_stock_a", 32'(bus.stock_a), 32'd5);
        check("mid_rst_stock_b", 32'(bus.stock_b), 32'd5);
        check("mid_rst_err_a", 32'(bus.err_a), 32'd0);
        check("mid_rst_status_b", 32'(bus.status_b), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
